// File: rtl/nn_io_pkg.sv
// Shared constants and types for the NN GPIO switch input path.
package nn_io_pkg;

  localparam int unsigned NN_SW_COUNT         = 6;
  localparam int unsigned NN_SW_VALID_IDX     = 0;
  localparam int unsigned NN_GPIO_SW_BASE     = 32;
  localparam int unsigned NN_DEBOUNCE_DEFAULT = 50000;
  localparam int unsigned NN_PRESS_CNT_W      = 16;

  typedef logic [NN_SW_COUNT-1:0] nn_sw_t;

endpackage : nn_io_pkg

// File: rtl/nn_debounce_bit.sv
// One switch bit: 2-flop synchroniser followed by a restart-on-glitch debounce counter.
module nn_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o
);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;

  // Count cycles the synchronised level disagrees with the stable level; accept on the last one.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser chain, counter and stable level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule : nn_debounce_bit

// File: rtl/nn_switch_conditioner.sv
// Conditions the user switches for the NN core: debounce, in_valid pulse with
// busy gating and a one-deep pending slot, and an accepted-press counter.
module nn_switch_conditioner
  import nn_io_pkg::*;
#(
  parameter int unsigned N_SW            = NN_SW_COUNT,
  parameter int unsigned VALID_IDX       = NN_SW_VALID_IDX,
  parameter int unsigned DEBOUNCE_CYCLES = NN_DEBOUNCE_DEFAULT
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [N_SW-1:0]           sw_raw_i,
  input  logic                      nn_busy_i,
  output logic [N_SW-1:0]           sw_stable_o,
  output logic                      in_valid_pulse_o,
  output logic                      pending_o,
  output logic [NN_PRESS_CNT_W-1:0] press_count_o
);

  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PRESS_W = NN_PRESS_CNT_W;

  logic [N_SW-1:0]    stable_w;
  logic               valid_dly_q;
  logic               rise_c;
  logic               pulse_q;
  logic               pulse_d;
  logic               pending_q;
  logic               pending_d;
  logic [PRESS_W-1:0] press_cnt_q;
  logic [PRESS_W-1:0] press_cnt_d;

  for (genvar gi = 0; gi < N_SW; gi++) begin : gen_sw
    nn_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk_i    (wb_clk_i),
      .rst_i    (wb_rst_i),
      .raw_i    (sw_raw_i[gi]),
      .stable_o (stable_w[gi])
    );
  end

  assign rise_c = stable_w[VALID_IDX] & ~valid_dly_q;

  // Issue decision: drain pending first, then fresh rise, else park it; a third press is dropped.
  always_comb begin
    pulse_d     = 1'b0;
    pending_d   = pending_q;
    press_cnt_d = press_cnt_q;
    if (pending_q && !nn_busy_i) begin
      pulse_d   = 1'b1;
      pending_d = rise_c;
    end else if (rise_c && !nn_busy_i && !pending_q) begin
      pulse_d = 1'b1;
    end else if (rise_c) begin
      pending_d = 1'b1;
    end
    if (rise_c && !(pending_q && nn_busy_i)) begin
      press_cnt_d = press_cnt_q + PRESS_W'(1);
    end
  end

  // Edge-detect delay, pulse, pending slot and press counter.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      valid_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
      pending_q   <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      valid_dly_q <= stable_w[VALID_IDX];
      pulse_q     <= pulse_d;
      pending_q   <= pending_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign sw_stable_o      = stable_w;
  assign in_valid_pulse_o = pulse_q;
  assign pending_o        = pending_q;
  assign press_count_o    = press_cnt_q;

endmodule : nn_switch_conditioner

// File: tb/tb_nn_switch_conditioner.sv
// Directed bench for nn_switch_conditioner with a 4-cycle debounce window.
module tb_nn_switch_conditioner;
  import nn_io_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  nn_sw_t      raw = '0;
  logic        busy = 1'b0;
  nn_sw_t      stable;
  logic        pulse;
  logic        pend;
  logic [15:0] cnt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  nn_switch_conditioner #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .wb_clk_i         (clk),
    .wb_rst_i         (rst),
    .sw_raw_i         (raw),
    .nn_busy_i        (busy),
    .sw_stable_o      (stable),
    .in_valid_pulse_o (pulse),
    .pending_o        (pend),
    .press_count_o    (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    nn_sw_t      raw;
    logic        busy;
    nn_sw_t      stable;
    logic        pulse;
    logic        pend;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input nn_sw_t r, input logic b, input nn_sw_t s,
                     input logic p, input logic pn, input logic [15:0] c);
    vec_t v;
    v.raw = r; v.busy = b; v.stable = s; v.pulse = p; v.pend = pn; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int pulses;

    // Row i: inputs applied before edge i, outputs expected after edge i.
    // Clean press of bit 0 together with bit 3: stable after edge 6, pulse after edge 7.
    for (int i = 1; i <= 5; i++) add(6'h09, 1'b0, 6'h00, 1'b0, 1'b0, 16'd0);
    add(6'h09, 1'b0, 6'h09, 1'b0, 1'b0, 16'd0);
    add(6'h09, 1'b0, 6'h09, 1'b1, 1'b0, 16'd1);
    add(6'h09, 1'b0, 6'h09, 1'b0, 1'b0, 16'd1);
    add(6'h09, 1'b0, 6'h09, 1'b0, 1'b0, 16'd1);
    // Bouncy release: 0,1,0,1 then held 0 from row 5 -> stable falls after row 10, no pulse.
    add(6'h08, 1'b0, 6'h09, 1'b0, 1'b0, 16'd1);
    add(6'h09, 1'b0, 6'h09, 1'b0, 1'b0, 16'd1);
    add(6'h08, 1'b0, 6'h09, 1'b0, 1'b0, 16'd1);
    add(6'h09, 1'b0, 6'h09, 1'b0, 1'b0, 16'd1);
    for (int i = 5; i <= 9; i++) add(6'h08, 1'b0, 6'h09, 1'b0, 1'b0, 16'd1);
    add(6'h08, 1'b0, 6'h08, 1'b0, 1'b0, 16'd1);
    add(6'h08, 1'b0, 6'h08, 1'b0, 1'b0, 16'd1);
    // Bouncy press: 1,0,1,0 then held 1 from row 5 -> stable after row 10, single pulse row 11.
    add(6'h09, 1'b0, 6'h08, 1'b0, 1'b0, 16'd1);
    add(6'h08, 1'b0, 6'h08, 1'b0, 1'b0, 16'd1);
    add(6'h09, 1'b0, 6'h08, 1'b0, 1'b0, 16'd1);
    add(6'h08, 1'b0, 6'h08, 1'b0, 1'b0, 16'd1);
    for (int i = 5; i <= 9; i++) add(6'h09, 1'b0, 6'h08, 1'b0, 1'b0, 16'd1);
    add(6'h09, 1'b0, 6'h09, 1'b0, 1'b0, 16'd1);
    add(6'h09, 1'b0, 6'h09, 1'b1, 1'b0, 16'd2);
    add(6'h09, 1'b0, 6'h09, 1'b0, 1'b0, 16'd2);

    // Reset state.
    ticks(2);
    chk("reset_stable", 16'(stable), 16'h0);
    chk("reset_pulse", 16'(pulse), 16'h0);
    chk("reset_pend", 16'(pend), 16'h0);
    chk("reset_cnt", cnt, 16'h0);
    #3 rst = 1'b0;
    tick();
    // The edge just taken saw raw=0; table rows start counting from the next edge.

    foreach (vecs[i]) begin
      raw  = vecs[i].raw;
      busy = vecs[i].busy;
      tick();
      chk($sformatf("vec%0d_stable", i), 16'(stable), 16'(vecs[i].stable));
      chk($sformatf("vec%0d_pulse", i), 16'(pulse), 16'(vecs[i].pulse));
      chk($sformatf("vec%0d_pend", i), 16'(pend), 16'(vecs[i].pend));
      chk($sformatf("vec%0d_cnt", i), cnt, vecs[i].cnt);
    end

    // Busy gating: press while busy parks it; busy falling releases one pulse.
    raw = 6'h08; ticks(8);
    chk("busy_released", 16'(stable), 16'h08);
    busy = 1'b1; raw = 6'h09; ticks(6);
    chk("busy_stable", 16'(stable), 16'h09);
    chk("busy_pend_early", 16'(pend), 16'h0);
    tick();
    chk("busy_pend", 16'(pend), 16'h1);
    chk("busy_cnt", cnt, 16'd3);
    pulses = 32'(pulse);
    for (int i = 0; i < 13; i++) begin tick(); pulses += 32'(pulse); end
    chk("busy_no_pulse", 16'(pulses), 16'd0);
    chk("busy_pend_hold", 16'(pend), 16'h1);
    busy = 1'b0; tick();
    chk("busy_drain_pulse", 16'(pulse), 16'h1);
    chk("busy_drain_pend", 16'(pend), 16'h0);
    tick();
    chk("busy_pulse_end", 16'(pulse), 16'h0);

    // Overflow: second press while one is pending is dropped.
    raw = 6'h08; ticks(8);
    busy = 1'b1; raw = 6'h09; ticks(7);
    chk("ovf_pend1", 16'(pend), 16'h1);
    chk("ovf_cnt1", cnt, 16'd4);
    raw = 6'h08; ticks(8);
    raw = 6'h09; ticks(8);
    chk("ovf_pend2", 16'(pend), 16'h1);
    chk("ovf_cnt2", cnt, 16'd4);
    busy = 1'b0; tick();
    chk("ovf_pulse", 16'(pulse), 16'h1);
    chk("ovf_pend_clr", 16'(pend), 16'h0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin tick(); pulses += 32'(pulse); end
    chk("ovf_single_pulse", 16'(pulses), 16'd0);

    // Coincident: busy falls in the rise cycle of a new press while one is pending.
    raw = 6'h08; ticks(8);
    busy = 1'b1; raw = 6'h09; ticks(7);
    chk("coin_pend", 16'(pend), 16'h1);
    chk("coin_cnt1", cnt, 16'd5);
    raw = 6'h08; ticks(8);
    raw = 6'h09; ticks(6);
    busy = 1'b0; tick();
    chk("coin_pulse1", 16'(pulse), 16'h1);
    chk("coin_pend_kept", 16'(pend), 16'h1);
    chk("coin_cnt2", cnt, 16'd6);
    tick();
    chk("coin_pulse2", 16'(pulse), 16'h1);
    chk("coin_pend_clr", 16'(pend), 16'h0);
    tick();
    chk("coin_pulse_end", 16'(pulse), 16'h0);

    // Asynchronous reset with a press pending and a release mid-debounce.
    raw = 6'h08; ticks(8);
    busy = 1'b1; raw = 6'h09; ticks(7);
    chk("rst_pre_pend", 16'(pend), 16'h1);
    raw = 6'h08; ticks(3);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_stable", 16'(stable), 16'h0);
    chk("rst_async_pulse", 16'(pulse), 16'h0);
    chk("rst_async_pend", 16'(pend), 16'h0);
    chk("rst_async_cnt", cnt, 16'h0);
    raw = 6'h09; busy = 1'b0;
    ticks(2);
    #3 rst = 1'b0;
    ticks(6);
    chk("pwrup_stable", 16'(stable), 16'h09);
    chk("pwrup_no_early_pulse", 16'(pulse), 16'h0);
    tick();
    chk("pwrup_pulse", 16'(pulse), 16'h1);
    chk("pwrup_cnt", cnt, 16'd1);
    tick();
    chk("pwrup_pulse_end", 16'(pulse), 16'h0);

    // Counter wrap from 0xFFFF.
    force dut.press_cnt_q = 16'hFFFF;
    tick();
    release dut.press_cnt_q;
    raw = 6'h08; ticks(8);
    chk("wrap_hold", cnt, 16'hFFFF);
    raw = 6'h09; ticks(7);
    chk("wrap_cnt", cnt, 16'h0000);
    chk("wrap_pulse", 16'(pulse), 16'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_nn_switch_conditioner
